// File: rtl/i2c_reg16_pkg.sv
// Shared types and constants for the 16-bit-address / 16-bit-data I2C register target.
package i2c_reg16_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StSubHi,
        StSubLo,
        StWrHi,
        StWrLo,
        StRdHi,
        StRdLo,
        StIgnore
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [15:0] ADDR_STEP = 16'd2;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus FILTER_LEN-sample glitch filter for one I2C line, with
// registered rise/fall pulses that coincide with the new filtered level.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            meta_q, sync_q;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // A new level is accepted once it has been seen on FILTER_LEN consecutive samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CntW'(FILTER_LEN - 1)) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = ~level_q & level_d;
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= line_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_reg16_slave.sv
// I2C target with big-endian 16-bit sub-address and 16-bit data, exposed as a
// synchronous register-file port with single-cycle read/write strobes.
module i2c_reg16_slave
    import i2c_reg16_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h10,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_scl,
    input  logic        i2c_sda_in,
    output logic        i2c_sda_oe,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (i2c_scl),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (i2c_sda_in),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    i2c_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        skip_q, skip_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] tx_q, tx_d;
    logic        mack_q, mack_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        cap_q, cap_d;

    logic        start_cond, stop_cond, active;
    logic [7:0]  byte_in;

    // An SCL edge in the same cycle turns an SDA edge into a plain data edge.
    assign start_cond = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop_cond  = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
    assign active     = (state_q != StIdle) && (state_q != StIgnore);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        skip_d    = skip_q;
        shift_d   = shift_q;
        hi_d      = hi_q;
        tx_d      = tx_q;
        mack_d    = mack_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        cap_d     = rd_q;
        byte_in   = {shift_q[6:0], sda_lvl};

        if (cap_q) begin
            tx_d = reg_rdata;
        end

        if (stop_cond) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_cond) begin
            state_d   = StDevAddr;
            bit_cnt_d = '0;
            skip_d    = 1'b1;
            oe_d      = 1'b0;
        end else if (scl_rise && active) begin
            if (bit_cnt_q < 4'd8) begin
                shift_d = byte_in;
                if (bit_cnt_q == 4'd7) begin
                    case (state_q)
                        StDevAddr: begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                busy_d = 1'b1;
                                rd_d   = byte_in[0];
                            end
                        end
                        StSubHi: addr_d[15:8] = byte_in;
                        StSubLo: addr_d[7:0]  = byte_in;
                        StWrHi:  hi_d         = byte_in;
                        StWrLo: begin
                            wr_d    = 1'b1;
                            wdata_d = {hi_q, byte_in};
                        end
                        default: ;
                    endcase
                end
            end else begin
                mack_d = sda_lvl;
                // Fetch the next word early so it is ready before the next byte is driven.
                if (state_q == StRdLo) begin
                    addr_d = addr_q + ADDR_STEP;
                    rd_d   = (sda_lvl == I2C_ACK);
                end
            end
        end else if (scl_fall && active) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else if (bit_cnt_q == 4'd8) begin
                bit_cnt_d = '0;
                oe_d      = 1'b0;
                case (state_q)
                    StDevAddr: state_d = shift_q[0] ? StRdHi : StSubHi;
                    StSubHi:   state_d = StSubLo;
                    StSubLo:   state_d = StWrHi;
                    StWrHi:    state_d = StWrLo;
                    StWrLo: begin
                        state_d = StWrHi;
                        addr_d  = addr_q + ADDR_STEP;
                    end
                    StRdHi:  state_d = (mack_q == I2C_NACK) ? StIgnore : StRdLo;
                    StRdLo:  state_d = (mack_q == I2C_NACK) ? StIgnore : StRdHi;
                    default: ;
                endcase
                if (state_d == StRdHi || state_d == StRdLo) begin
                    oe_d = ~tx_q[15];
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    case (state_q)
                        StDevAddr: begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                oe_d = 1'b1;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                        StRdHi, StRdLo: oe_d = 1'b0;
                        default:        oe_d = 1'b1;
                    endcase
                end else if (state_q == StRdHi || state_q == StRdLo) begin
                    oe_d = ~tx_q[15];
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            skip_q    <= 1'b0;
            shift_q   <= '0;
            hi_q      <= '0;
            tx_q      <= '0;
            mack_q    <= I2C_NACK;
            addr_q    <= '0;
            wdata_q   <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            skip_q    <= skip_d;
            shift_q   <= shift_d;
            hi_q      <= hi_d;
            tx_q      <= tx_d;
            mack_q    <= mack_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cap_q     <= cap_d;
        end
    end

    assign i2c_sda_oe = oe_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign reg_wr     = wr_q;
    assign reg_rd     = rd_q;
    assign busy       = busy_q;

endmodule
